if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Generic payload width with a valid/ready handshake on both sides, replacing the global stall wire.
- Two-entry skid buffer, so in_ready is a registered output and upstream timing is cut.
- Synchronous flush that inserts bubbles, plus saturating stall and flush event counters for performance debug.
- Sits between any two pipeline stages; first instance is IF->ID with payload {inst, cur_pc, next_pc}.

Parameters:
- DATA_W, 96, payload width in bits (min 1).
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data after reset, on flush, and when the stage empties (a NOP encoding for IF/ID).
- CNT_W, 32, width of the performance counters (min 1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush; discards all held entries and any same-cycle input
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  stage can accept; registered output
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a valid entry; registered output
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload; registered output
- occupancy  out  2  number of entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  number of cycles with flush=1, saturating

Behaviour:
- Storage is a main register (drives out_data) and a skid register. The state is one of EMPTY (occ 0), ONE (occ 1) or FULL (occ 2).
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer happens only on a clock edge where the fire signal is 1.
- Derived outputs: out_valid = (state != EMPTY); in_ready = (state != FULL). Both are decoded from state flops only; there is no combinational path from any input.
- Reset (async, rst=1), effective immediately:
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - main=BUBBLE_VAL, skid=BUBBLE_VAL.
  - stall_cnt=0, flush_cnt=0.
- Priority order: rst, then flush, then normal transitions.
- Flush (synchronous, next edge):
  - state=EMPTY; main and skid load BUBBLE_VAL.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire counts as completed for the consumer.
  - Counters are not cleared by flush.
- EMPTY state:
  - in_fire: main<=in_data, go to ONE. Latency is 1 cycle from input to out_valid.
  - Otherwise hold.
- ONE state:
  - in_fire and out_fire: main<=in_data, stay in ONE.
  - in_fire only: skid<=in_data, go to FULL.
  - out_fire only: main<=BUBBLE_VAL, go to EMPTY.
  - Neither: hold.
- FULL state (in_ready=0, so in_valid is ignored):
  - out_fire: main<=skid, skid<=BUBBLE_VAL, go to ONE.
  - Otherwise hold.
- Ordering: strict FIFO. No payload is duplicated or dropped unless a flush occurs.
- Throughput: 1 transfer per cycle when out_ready is held at 1.
- out_data is stable while out_valid=1 and out_ready=0.
- Counters:
  - Each increments by 1 on its condition and saturates at 2^CNT_W-1 (no wrap).
  - stall_cnt samples the pre-edge out_valid and out_ready.
  - flush_cnt increments in every cycle with flush=1, including when the stage is already EMPTY.
- Reset asserted mid-transfer: all state is lost immediately, outputs return to their reset values, and no partial update occurs.

Test Plan:
- Reset and idle: assert rst, release with in_valid=0 -> out_valid=0, in_ready=1, out_data=0, occupancy=0, both counters 0.
- Streaming: out_ready=1; send 0xA, 0xB, 0xC on consecutive cycles -> out_data=0xA, 0xB, 0xC one cycle later each; in_ready stays 1; stall_cnt=0.
- Backpressure and skid: out_ready=0; send 0x1 then 0x2 -> occupancy=2 and in_ready=0; 0x3 held at in_valid is not taken. Raise out_ready -> outputs 0x1, 0x2, 0x3 in order, with no loss or duplicate. stall_cnt equals the number of cycles with out_valid=1 and out_ready=0.
- Flush in FULL with in_valid=1 (0x9): next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0x9 never appears on out_data; flush_cnt=1.
- Saturation with CNT_W=2: hold out_valid=1 and out_ready=0 for 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
- Async reset while FULL, asserted between clock edges -> outputs go to reset values before the next edge; the first transfer after release is 0x5, seen one cycle later.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// Two-entry skid-buffered pipeline stage with valid/ready on both sides,
// synchronous bubble-inserting flush and saturating stall/flush counters.
module if_id_skid_stage #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_in_fire;
  logic w_out_fire;

  // Handshake flags come straight from the state encoding, so no input reaches them.
  assign out_valid  = (r_state != S_EMPTY);
  assign in_ready   = (r_state != S_FULL);
  assign occupancy  = r_state;
  assign out_data   = r_main;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else if (flush) begin
      r_state <= S_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= in_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid  <= in_data;
            r_state <= S_FULL;
          end else if (w_out_fire) begin
            r_main  <= BUBBLE_VAL;
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_skid  <= BUBBLE_VAL;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_main  <= BUBBLE_VAL;
          r_skid  <= BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (flush && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: a queue-based reference model tracks
// expected contents and counters; a negedge monitor compares every cycle.
module tb_if_id_skid_stage;

  localparam int              DW   = 16;
  localparam logic [DW-1:0]   BUB  = 16'h0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;

  // Narrow-counter instance for the saturation check; never drained.
  logic          s_flush;
  logic          s_in_valid;
  logic          s_in_ready;
  logic [7:0]    s_in_data;
  logic          s_out_valid;
  logic          s_out_ready;
  logic [7:0]    s_out_data;
  logic [1:0]    s_occupancy;
  logic [1:0]    s_stall_cnt;
  logic [1:0]    s_flush_cnt;

  always #5 clk = ~clk;

  if_id_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_skid_stage #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: a FIFO of at most two payloads plus expected counters.
  logic [DW-1:0] exp_q[$];
  logic [31:0]   exp_stall;
  logic [31:0]   exp_flush;
  int            s_exp_cnt;
  logic [1:0]    s_exp_stall;

  always @(posedge clk or posedge rst) begin
    bit m_out_fire;
    bit m_in_fire;
    if (rst) begin
      exp_q.delete();
      exp_stall   = 0;
      exp_flush   = 0;
      s_exp_cnt   = 0;
      s_exp_stall = 0;
    end else begin
      m_out_fire = (exp_q.size() > 0) && out_ready;
      m_in_fire  = in_valid && (exp_q.size() < 2);
      if ((exp_q.size() > 0) && !out_ready && (exp_stall != 32'hFFFF_FFFF))
        exp_stall = exp_stall + 1;
      if (flush && (exp_flush != 32'hFFFF_FFFF))
        exp_flush = exp_flush + 1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_out_fire) void'(exp_q.pop_front());
        if (m_in_fire) exp_q.push_back(in_data);
      end
      if ((s_exp_cnt > 0) && (s_exp_stall != 2'd3))
        s_exp_stall = s_exp_stall + 2'd1;
      if (s_in_valid && (s_exp_cnt < 2))
        s_exp_cnt = s_exp_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : BUB;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
    chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
    chk("out_data",  64'(out_data),  64'(head));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    chk("sat_out_valid", 64'(s_out_valid), 64'(s_exp_cnt > 0));
    chk("sat_stall_cnt", 64'(s_stall_cnt), 64'(s_exp_stall));
    chk("sat_flush_cnt", 64'(s_flush_cnt), 64'd0);
    if (out_valid && out_ready && !rst) begin
      n_xfer++;
      $display("xfer %0d: out_data=%h flush=%0b t=%0t", n_xfer, out_data, flush, $time);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer d until the stage accepts it, bounded.
  task automatic send_hold(input logic [DW-1:0] d);
    logic ok;
    int   k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    do begin
      @(posedge clk);
      ok = in_ready;
      k++;
    end while (!ok && k < 20);
    #1;
    if (!ok) begin
      $display("FAIL accept_timeout: data %h not accepted within 20 cycles", d);
      $fatal(1, "accept timeout");
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);

    out_ready = 1'b1;
    send_hold(16'h000A);
    send_hold(16'h000B);
    send_hold(16'h000C);
    in_valid = 1'b0;
    cyc(3);

    out_ready = 1'b0;
    send_hold(16'h0001);
    send_hold(16'h0002);
    in_valid = 1'b1; in_data = 16'h0003;
    cyc(3);
    out_ready = 1'b1;
    send_hold(16'h0003);
    in_valid = 1'b0;
    cyc(4);

    out_ready = 1'b0;
    send_hold(16'h0004);
    send_hold(16'h0006);
    in_valid = 1'b1; in_data = 16'h0009; flush = 1'b1;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    cyc(2);
    out_ready = 1'b1;
    cyc(2);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = DW'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      cyc(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cyc(4);

    s_in_valid = 1'b1; s_in_data = 8'h5A;
    cyc(1);
    s_in_valid = 1'b0;
    cyc(8);

    out_ready = 1'b0;
    send_hold(16'h0007);
    send_hold(16'h0008);
    in_valid = 1'b0;
    cyc(1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_hold(16'h0005);
    in_valid = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
